// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared defaults and the fetch packet type for the RV32
//               instruction-fetch slice.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int unsigned     RV_XLEN     = 32;
    localparam int unsigned     RV_ILEN     = 32;
    localparam logic [31:0]     RV_RESET_PC = 32'h0000_0000;

    // One decoded-side handoff: the instruction word and the PC it came from.
    typedef struct packed {
        logic [RV_XLEN-1:0] pc;
        logic [RV_ILEN-1:0] instr;
    } fetch_pkt_t;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/riscv_fetch_unit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Prefetch FIFO. Head is read straight out of the storage
//               registers, so a word pushed in cycle N is visible in N+1.
//               Flush empties the FIFO in one edge.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = fetch_pkt_t
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    input  logic                         flush,
    output T                             head,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned        c_ptr_w = $clog2(DEPTH);
    localparam int unsigned        c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

    T                   mem_q [DEPTH];
    T                   mem_d [DEPTH];
    logic [c_ptr_w-1:0] wr_q, wr_d;
    logic [c_ptr_w-1:0] rd_q, rd_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               push_ok;
    logic               pop_ok;

    // Status flags and handshake qualification; a push on a full FIFO is
    // only taken when the head leaves in the same cycle.
    always_comb begin
        empty   = (cnt_q == '0);
        full    = (cnt_q == c_depth);
        count   = cnt_q;
        head    = mem_q[rd_q];
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
    end

    // Next-state for storage, pointers and occupancy; flush wins.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + c_ptr_w'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + c_ptr_w'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt_d = cnt_q + c_cnt_w'(1);
                2'b01:   cnt_d = cnt_q - c_cnt_w'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Data storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule : fetch_fifo
`default_nettype wire

// File: rtl/riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : riscv_fetch_unit
// Description : Decoupled RV32 fetch stage. Owns the PC, issues pipelined
//               requests under a credit rule so every in-flight word has a
//               FIFO slot, tags responses with their issue PC and hands
//               {pc, instr} to decode. Redirects flush and discard stale
//               responses.
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_fetch_unit
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN            = RV_XLEN,
    parameter int unsigned     ILEN            = RV_ILEN,
    parameter logic [XLEN-1:0] RESET_PC        = RV_RESET_PC,
    parameter int unsigned     FIFO_DEPTH      = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            resetn,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [ILEN-1:0] if_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int unsigned        c_out_w   = $clog2(MAX_OUTSTANDING + 1);
    localparam int unsigned        c_fcnt_w  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned        c_tag_w   = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [c_out_w-1:0] c_max_out = c_out_w'(MAX_OUTSTANDING);
    localparam logic [c_tag_w-1:0] c_tag_end = c_tag_w'(MAX_OUTSTANDING - 1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } pkt_t;

    logic [XLEN-1:0]     pc_q, pc_d;
    logic [c_out_w-1:0]  out_q, out_d;
    logic [c_out_w-1:0]  disc_q, disc_d;
    logic [c_tag_w-1:0]  tag_wr_q, tag_wr_d;
    logic [c_tag_w-1:0]  tag_rd_q, tag_rd_d;
    logic [XLEN-1:0]     tag_mem_q [MAX_OUTSTANDING];
    logic [XLEN-1:0]     tag_mem_d [MAX_OUTSTANDING];

    logic                issue;
    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_flush;
    logic                fifo_empty;
    logic                fifo_full;
    logic [c_fcnt_w-1:0] fifo_count;
    pkt_t                fifo_in;
    pkt_t                fifo_head;
    logic                unused_redirect_lsbs;

    // The low PC bits of a redirect target are forced to zero.
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Tag queue pointer advance, wrapping at the configured depth.
    function automatic logic [c_tag_w-1:0] tag_next(input logic [c_tag_w-1:0] p);
        return (p == c_tag_end) ? '0 : p + c_tag_w'(1);
    endfunction

    // Issue gating: held off by redirect, the outstanding limit and the
    // credit rule; gated by resetn so it drops the moment reset asserts.
    always_comb begin
        imem_req  = resetn && !redirect_valid && (out_q < c_max_out) &&
                    ((32'(fifo_count) + 32'(out_q)) < FIFO_DEPTH);
        imem_addr = pc_q;
        issue     = imem_req && imem_gnt;
        if_valid  = !fifo_empty;
        if_pc     = fifo_head.pc;
        if_instr  = fifo_head.instr;
        fifo_pop  = if_ready && !fifo_empty && !redirect_valid;
    end

    // PC, counters and tag queue next-state; redirect overrides everything.
    always_comb begin
        pc_d          = pc_q;
        out_d         = out_q;
        disc_d        = disc_q;
        tag_wr_d      = tag_wr_q;
        tag_rd_d      = tag_rd_q;
        tag_mem_d     = tag_mem_q;
        fifo_push     = 1'b0;
        fifo_flush    = 1'b0;
        fifo_in.pc    = tag_mem_q[tag_rd_q];
        fifo_in.instr = imem_rdata;
        if (redirect_valid) begin
            // Everything still in flight becomes stale; a response landing
            // this cycle is dropped here and so is not counted again.
            pc_d       = {redirect_pc[XLEN-1:2], 2'b00};
            out_d      = imem_rvalid ? (out_q - c_out_w'(1)) : out_q;
            disc_d     = out_d;
            tag_wr_d   = '0;
            tag_rd_d   = '0;
            fifo_flush = 1'b1;
        end else begin
            if (issue) begin
                pc_d                = pc_q + XLEN'(4);
                tag_mem_d[tag_wr_q] = pc_q;
                tag_wr_d            = tag_next(tag_wr_q);
            end
            if (imem_rvalid) begin
                if (disc_q != '0) begin
                    disc_d = disc_q - c_out_w'(1);
                end else begin
                    fifo_push = 1'b1;
                    tag_rd_d  = tag_next(tag_rd_q);
                end
            end
            case ({issue, imem_rvalid})
                2'b10:   out_d = out_q + c_out_w'(1);
                2'b01:   out_d = out_q - c_out_w'(1);
                default: out_d = out_q;
            endcase
        end
    end

    // Control registers with asynchronous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q     <= RESET_PC;
            out_q    <= '0;
            disc_q   <= '0;
            tag_wr_q <= '0;
            tag_rd_q <= '0;
        end else begin
            pc_q     <= pc_d;
            out_q    <= out_d;
            disc_q   <= disc_d;
            tag_wr_q <= tag_wr_d;
            tag_rd_q <= tag_rd_d;
        end
    end

    // Issue-PC tag storage; only entries between the pointers are meaningful.
    always_ff @(posedge clk) begin
        tag_mem_q <= tag_mem_d;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (pkt_t)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (fifo_push),
        .push_data (fifo_in),
        .pop       (fifo_pop),
        .flush     (fifo_flush),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (!resetn)
        !(imem_rvalid && (out_q == '0)));

    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (!resetn)
        !(fifo_push && fifo_full && !fifo_pop));

endmodule : riscv_fetch_unit
`default_nettype wire

// File: tb/tb_riscv_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_riscv_fetch_unit
// Description : Self-checking bench for riscv_fetch_unit. A memory model
//               returns words in issue order after a programmable latency;
//               each kept response pushes the expected {pc, instr} onto a
//               scoreboard that is popped on every decode handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_fetch_unit;

    logic        clk;
    logic        resetn;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    riscv_fetch_unit dut (
        .clk            (clk),
        .resetn         (resetn),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          kill;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          n_checks;
    int          n_fail;
    int          cyc;
    int          lat;
    bit          cfg_ready;
    bit          cfg_gnt;
    int          n_pops;
    int          n_grants;
    bit          popped_now;
    logic [31:0] last_pop_pc;
    int          first_grant_cyc;
    int          first_valid_cyc;
    bit          obs_overlap;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at the falling edge, observe 1 time unit later.
    task automatic tick(input bit redir, input logic [31:0] rpc);
        mreq_t r;
        exp_t  e;
        @(negedge clk);
        cyc++;
        redirect_valid = redir;
        redirect_pc    = rpc;
        if_ready       = cfg_ready;
        imem_gnt       = cfg_gnt;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
        popped_now  = 1'b0;
        obs_overlap = redir && if_valid && if_ready && imem_rvalid;
        if (if_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (if_valid && if_ready && !redir) begin
            popped_now  = 1'b1;
            n_pops++;
            last_pop_pc = if_pc;
            if (exp_q.size() == 0) begin
                check("spurious_pop", {32'h0, if_pc}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", {32'h0, if_pc}, {32'h0, e.pc});
                check("pop_instr", {32'h0, if_instr}, {32'h0, e.instr});
            end
        end
        if (imem_rvalid) begin
            r = mem_q.pop_front();
            if (!r.kill && !redir) exp_q.push_back('{r.addr, mem_word(r.addr)});
        end
        if (redir) begin
            exp_q.delete();
            foreach (mem_q[i]) mem_q[i].kill = 1'b1;
        end
        if (imem_req && imem_gnt) begin
            n_grants++;
            if (first_grant_cyc < 0) first_grant_cyc = cyc;
            mem_q.push_back('{imem_addr, cyc + lat, 1'b0});
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'h0);
    endtask

    // Bounded wait for the next decode handshake and check its PC.
    task automatic run_until_pop(input string tag, input logic [31:0] exp_pc);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1'b0, 32'h0);
            seen = popped_now;
        end
        if (seen) check(tag, {32'h0, last_pop_pc}, {32'h0, exp_pc});
        else      check(tag, 64'h1_0000_0000, {32'h0, exp_pc});
    endtask

    // Stop issuing and let every kept word reach decode.
    task automatic drain(input string tag);
        cfg_gnt   = 1'b0;
        cfg_ready = 1'b1;
        run(8);
        check(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_q.delete();
        exp_q.delete();
        cyc             = 0;
        n_pops          = 0;
        n_grants        = 0;
        first_grant_cyc = -1;
        first_valid_cyc = -1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",   {63'h0, imem_req}, 64'd0);
        check("rst_valid", {63'h0, if_valid}, 64'd0);
        check("rst_addr",  {32'h0, imem_addr}, 64'h0);
        resetn = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        n_checks = 0;
        n_fail   = 0;
        lat      = 1;

        // 1: streaming, 1-cycle memory
        do_reset();
        lat = 1; cfg_ready = 1'b1; cfg_gnt = 1'b1;
        run(4);
        check("t1_first_latency", 64'(first_valid_cyc - first_grant_cyc), 64'd2);
        p0 = n_pops;
        run(10);
        check("t1_throughput", 64'(n_pops - p0), 64'd10);
        drain("t1_drain");

        // 2: decode stalled, FIFO fills to exactly its depth
        do_reset();
        lat = 1; cfg_ready = 1'b0; cfg_gnt = 1'b1;
        run(20);
        check("t2_grants",   64'(n_grants), 64'd4);
        check("t2_req_low",  {63'h0, imem_req}, 64'd0);
        check("t2_valid",    {63'h0, if_valid}, 64'd1);
        cfg_ready = 1'b1; cfg_gnt = 1'b0;
        run(8);
        check("t2_pops",     64'(n_pops), 64'd4);
        check("t2_last_pc",  {32'h0, last_pop_pc}, 64'hC);
        check("t2_empty",    64'(exp_q.size()), 64'd0);

        // 3: redirect with two fetches in flight
        do_reset();
        lat = 3; cfg_ready = 1'b1; cfg_gnt = 1'b1;
        run(2);
        tick(1'b1, 32'h100);
        tick(1'b0, 32'h0);
        check("t3_valid_after_redirect", {63'h0, if_valid}, 64'd0);
        run_until_pop("t3_first_pc", 32'h100);
        drain("t3_drain");

        // 4: redirect coinciding with a pop and a returning word
        do_reset();
        lat = 1; cfg_ready = 1'b1; cfg_gnt = 1'b1;
        run(5);
        tick(1'b1, 32'h100);
        check("t4_overlap", {63'h0, obs_overlap}, 64'd1);
        tick(1'b0, 32'h0);
        check("t4_valid_after_redirect", {63'h0, if_valid}, 64'd0);
        run_until_pop("t4_first_pc", 32'h100);

        // 5: unaligned redirect target and PC wrap
        tick(1'b1, 32'h103);
        tick(1'b0, 32'h0);
        check("t5_align", {32'h0, imem_addr}, 64'h100);
        tick(1'b1, 32'hFFFF_FFFC);
        tick(1'b0, 32'h0);
        check("t5_top_addr", {32'h0, imem_addr}, 64'hFFFF_FFFC);
        check("t5_top_req",  {63'h0, imem_req}, 64'd1);
        tick(1'b0, 32'h0);
        check("t5_wrap_addr", {32'h0, imem_addr}, 64'h0);
        run_until_pop("t5_first_pc", 32'hFFFF_FFFC);
        drain("t5_drain");

        // 6: asynchronous reset mid-burst
        do_reset();
        lat = 2; cfg_ready = 1'b0; cfg_gnt = 1'b1;
        run(5);
        check("t6_pre_valid", {63'h0, if_valid}, 64'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6_valid_async", {63'h0, if_valid}, 64'd0);
        check("t6_req_async",   {63'h0, imem_req}, 64'd0);
        check("t6_addr_async",  {32'h0, imem_addr}, 64'h0);
        do_reset();
        lat = 1; cfg_ready = 1'b1; cfg_gnt = 1'b1;
        run_until_pop("t6_restart_pc", 32'h0);
        drain("t6_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_riscv_fetch_unit
`default_nettype wire
